// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit bus: hazard/BHT/redirect inputs and
// pipelined PC, metadata and counter outputs.
interface fetch_pc_unit_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             if_stall;
  logic             if_is_compressed;
  logic             if_prediction;
  logic [PC_W-1:0]  if_PBT;
  logic             id_jump;
  logic [PC_W-1:0]  id_jump_target;
  logic             exe_flush;
  logic [PC_W-1:0]  exe_CNI;
  logic [PC_W-1:0]  if_PC;
  logic [PC_W-1:0]  id_PC;
  logic [PC_W-1:0]  exe_PC;
  logic             id_valid;
  logic             exe_valid;
  logic             id_predicted;
  logic             exe_predicted;
  logic [PC_W-1:0]  id_PBT;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] jump_count;

  modport master (
    output if_stall, if_is_compressed, if_prediction, if_PBT,
    output id_jump, id_jump_target, exe_flush, exe_CNI,
    input  if_PC, id_PC, exe_PC, id_valid, exe_valid,
    input  id_predicted, exe_predicted, id_PBT,
    input  flush_count, jump_count
  );

  modport slave (
    input  if_stall, if_is_compressed, if_prediction, if_PBT,
    input  id_jump, id_jump_target, exe_flush, exe_CNI,
    output if_PC, id_PC, exe_PC, id_valid, exe_valid,
    output id_predicted, exe_predicted, id_PBT,
    output flush_count, jump_count
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register, next-PC select, IF/ID and ID/EXE
// metadata pipeline, and saturating redirect counters.
module fetch_pc_unit #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input logic             CLK,
  input logic             rst,
  fetch_pc_unit_if.slave  bus
);

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  id_pc_q;
  logic [PC_W-1:0]  id_pbt_q;
  logic             id_valid_q;
  logic             id_pred_q;
  logic [PC_W-1:0]  exe_pc_q;
  logic             exe_valid_q;
  logic             exe_pred_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] jump_cnt_q;

  logic             take_jump;
  logic             sel_flush;
  logic             sel_jump;
  logic             sel_hold;
  logic             sel_pred;
  logic             sel_seq;
  logic [PC_W-1:0]  pc_step;
  logic [PC_W-1:0]  next_pc;

  // A jump only counts for a live ID instruction and loses
  // to an older EXE flush.
  assign take_jump = bus.id_jump & id_valid_q & ~bus.exe_flush;

  assign sel_flush = bus.exe_flush;
  assign sel_jump  = take_jump;
  assign sel_hold  = ~sel_flush & ~sel_jump & bus.if_stall;
  assign sel_pred  = ~sel_flush & ~sel_jump & ~bus.if_stall
                   & bus.if_prediction;
  assign sel_seq   = ~sel_flush & ~sel_jump & ~bus.if_stall
                   & ~bus.if_prediction;

  assign pc_step = bus.if_is_compressed ? PC_W'(1) : PC_W'(2);

  // Next-PC select from one-hot priority-resolved sources.
  always_comb begin
    next_pc = pc_q + pc_step;
    unique case (1'b1)
      sel_flush: next_pc = bus.exe_CNI;
      sel_jump:  next_pc = bus.id_jump_target;
      sel_hold:  next_pc = pc_q;
      sel_pred:  next_pc = bus.if_PBT;
      sel_seq:   next_pc = pc_q + pc_step;
      default:   next_pc = pc_q + pc_step;
    endcase
  end

  // PC register.
  always_ff @(posedge CLK) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= next_pc;
  end

  // IF/ID register: squash on redirect, hold on stall.
  always_ff @(posedge CLK) begin
    if (rst) begin
      id_pc_q    <= '0;
      id_pbt_q   <= '0;
      id_valid_q <= 1'b0;
      id_pred_q  <= 1'b0;
    end else if (bus.exe_flush || take_jump) begin
      id_valid_q <= 1'b0;
      id_pred_q  <= 1'b0;
    end else if (!bus.if_stall) begin
      id_pc_q    <= pc_q;
      id_pbt_q   <= bus.if_PBT;
      id_valid_q <= 1'b1;
      id_pred_q  <= bus.if_prediction;
    end
  end

  // ID/EXE register: bubble on flush or stall.
  always_ff @(posedge CLK) begin
    if (rst) begin
      exe_pc_q    <= '0;
      exe_valid_q <= 1'b0;
      exe_pred_q  <= 1'b0;
    end else if (bus.exe_flush || bus.if_stall) begin
      exe_valid_q <= 1'b0;
      exe_pred_q  <= 1'b0;
    end else begin
      exe_pc_q    <= id_pc_q;
      exe_valid_q <= id_valid_q;
      exe_pred_q  <= id_pred_q;
    end
  end

  // Saturating redirect counters.
  always_ff @(posedge CLK) begin
    if (rst) begin
      flush_cnt_q <= '0;
      jump_cnt_q  <= '0;
    end else begin
      if (bus.exe_flush && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + 1'b1;
      if (take_jump && !(&jump_cnt_q))
        jump_cnt_q <= jump_cnt_q + 1'b1;
    end
  end

  assign bus.if_PC         = pc_q;
  assign bus.id_PC         = id_pc_q;
  assign bus.id_PBT        = id_pbt_q;
  assign bus.id_valid      = id_valid_q;
  assign bus.id_predicted  = id_pred_q;
  assign bus.exe_PC        = exe_pc_q;
  assign bus.exe_valid     = exe_valid_q;
  assign bus.exe_predicted = exe_pred_q;
  assign bus.flush_count   = flush_cnt_q;
  assign bus.jump_count    = jump_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed plan steps plus random
// traffic against a behavioural pipeline model.
module tb_fetch_pc_unit;

  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  fetch_pc_unit_if #(.PC_W(10), .CNT_W(16)) b1 ();
  fetch_pc_unit_if #(.PC_W(10), .CNT_W(2))  b2 ();

  fetch_pc_unit #(.PC_W(10), .RESET_PC(10'h000), .CNT_W(16)) dut1 (
    .CLK(CLK), .rst(rst), .bus(b1.slave)
  );
  fetch_pc_unit #(.PC_W(10), .RESET_PC(10'h000), .CNT_W(2)) dut2 (
    .CLK(CLK), .rst(rst), .bus(b2.slave)
  );

  assign b2.if_stall         = b1.if_stall;
  assign b2.if_is_compressed = b1.if_is_compressed;
  assign b2.if_prediction    = b1.if_prediction;
  assign b2.if_PBT           = b1.if_PBT;
  assign b2.id_jump          = b1.id_jump;
  assign b2.id_jump_target   = b1.id_jump_target;
  assign b2.exe_flush        = b1.exe_flush;
  assign b2.exe_CNI          = b1.exe_CNI;

  int n_vec = 0;
  int n_err = 0;

  int m_pc, m_idpc, m_idpbt, m_idv, m_idpred;
  int m_expc, m_exv, m_expred, m_fc, m_jc, m_fc2, m_jc2;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit r, bit st, bit cm, bit pr, int pbt,
                       bit jp, int jt, bit fl, int cni);
    rst                 = r;
    b1.if_stall         = st;
    b1.if_is_compressed = cm;
    b1.if_prediction    = pr;
    b1.if_PBT           = 10'(pbt);
    b1.id_jump          = jp;
    b1.id_jump_target   = 10'(jt);
    b1.exe_flush        = fl;
    b1.exe_CNI          = 10'(cni);
  endtask

  // Reference: apply the documented pipeline rules for one edge.
  task automatic model_step();
    int o_idpc, o_idv, o_idpred;
    bit acc;
    o_idpc = m_idpc; o_idv = m_idv; o_idpred = m_idpred;
    if (rst) begin
      m_pc = 0; m_idpc = 0; m_idpbt = 0; m_idv = 0; m_idpred = 0;
      m_expc = 0; m_exv = 0; m_expred = 0;
      m_fc = 0; m_jc = 0; m_fc2 = 0; m_jc2 = 0;
      return;
    end
    acc = b1.id_jump && (o_idv == 1) && !b1.exe_flush;
    if (b1.exe_flush) begin
      m_fc  = (m_fc  < 65535) ? m_fc + 1  : m_fc;
      m_fc2 = (m_fc2 < 3)     ? m_fc2 + 1 : m_fc2;
    end
    if (acc) begin
      m_jc  = (m_jc  < 65535) ? m_jc + 1  : m_jc;
      m_jc2 = (m_jc2 < 3)     ? m_jc2 + 1 : m_jc2;
    end
    if (b1.exe_flush || acc) begin
      m_idv = 0; m_idpred = 0;
    end else if (!b1.if_stall) begin
      m_idpc = m_pc; m_idpbt = int'(b1.if_PBT);
      m_idv = 1; m_idpred = int'(b1.if_prediction);
    end
    if (b1.exe_flush || b1.if_stall) begin
      m_exv = 0; m_expred = 0;
    end else begin
      m_expc = o_idpc; m_exv = o_idv; m_expred = o_idpred;
    end
    if (b1.exe_flush)          m_pc = int'(b1.exe_CNI);
    else if (acc)              m_pc = int'(b1.id_jump_target);
    else if (b1.if_stall)      m_pc = m_pc;
    else if (b1.if_prediction) m_pc = int'(b1.if_PBT);
    else m_pc = (m_pc + (b1.if_is_compressed ? 1 : 2)) % 1024;
  endtask

  task automatic check_all();
    chk("if_PC",        32'(b1.if_PC),         32'(m_pc));
    chk("id_PC",        32'(b1.id_PC),         32'(m_idpc));
    chk("id_PBT",       32'(b1.id_PBT),        32'(m_idpbt));
    chk("id_valid",     32'(b1.id_valid),      32'(m_idv));
    chk("id_pred",      32'(b1.id_predicted),  32'(m_idpred));
    chk("exe_PC",       32'(b1.exe_PC),        32'(m_expc));
    chk("exe_valid",    32'(b1.exe_valid),     32'(m_exv));
    chk("exe_pred",     32'(b1.exe_predicted), 32'(m_expred));
    chk("flush_count",  32'(b1.flush_count),   32'(m_fc));
    chk("jump_count",   32'(b1.jump_count),    32'(m_jc));
    chk("if_PC_w2",     32'(b2.if_PC),         32'(m_pc));
    chk("flush_cnt_w2", 32'(b2.flush_count),   32'(m_fc2));
    chk("jump_cnt_w2",  32'(b2.jump_count),    32'(m_jc2));
  endtask

  task automatic tick();
    @(negedge CLK);
    model_step();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    m_pc = 0; m_idv = 0; m_exv = 0;
    tick();
    tick();
    chk("reset_pc", 32'(b1.if_PC), 32'h0);
    chk("reset_fc", 32'(b1.flush_count), 32'h0);

    // Sequential mix: 0 -> 1 -> 3 -> 4.
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("seq_pc1", 32'(b1.if_PC), 32'h1);
    chk("seq_idv", 32'(b1.id_valid), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("seq_pc3", 32'(b1.if_PC), 32'h3);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("seq_pc4", 32'(b1.if_PC), 32'h4);

    // Reach 0x010 through an ID jump, then predict taken.
    drive(0, 0, 1, 0, 0, 1, 'h010, 0, 0); tick();
    chk("jump_pc", 32'(b1.if_PC), 32'h010);
    drive(0, 0, 1, 1, 'h120, 0, 0, 0, 0); tick();
    chk("pred_pc", 32'(b1.if_PC), 32'h120);
    chk("pred_idp", 32'(b1.id_predicted), 32'h1);
    chk("pred_pbt", 32'(b1.id_PBT), 32'h120);

    // Flush while stalled.
    drive(0, 1, 1, 0, 0, 0, 0, 1, 'h044); tick();
    chk("fst_pc", 32'(b1.if_PC), 32'h044);
    chk("fst_idv", 32'(b1.id_valid), 32'h0);
    chk("fst_exv", 32'(b1.exe_valid), 32'h0);
    chk("fst_fc", 32'(b1.flush_count), 32'h1);

    // Flush and jump together: flush wins.
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 1, 'h200, 1, 'h0AA); tick();
    chk("sim_pc", 32'(b1.if_PC), 32'h0AA);
    chk("sim_jc", 32'(b1.jump_count), 32'h1);

    // Wrap-around at 0x3FF.
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 1, 'h3FF, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("wrap_pc", 32'(b1.if_PC), 32'h001);

    // Five back-to-back flushes, each with its own target.
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 'h100 + i); tick();
      chk("ff_pc", 32'(b1.if_PC), 32'('h100 + i));
    end
    chk("sat_fc2", 32'(b2.flush_count), 32'h3);

    // Reset while stalled.
    drive(0, 0, 1, 1, 'h155, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 1, 'h155, 1, 'h77, 1, 'h66); tick();
    chk("mrst_pc", 32'(b1.if_PC), 32'h0);
    chk("mrst_idv", 32'(b1.id_valid), 32'h0);
    chk("mrst_fc", 32'(b1.flush_count), 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0,
            int'($urandom_range(0, 1023)),
            $urandom_range(0, 4) == 0,
            int'($urandom_range(0, 1023)),
            $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 1023)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
